// File: rtl/instruction_fetch_stage.sv
// instruction_fetch_stage: IF stage of the 5-stage MIPS pipeline.
// Owns the PC and next-PC select (PC+4, branch, j, jr), and drives the
// instruction memory word address. It latches the fetched word and its
// PC+4 into the IF/ID register, honouring stall, flush and redirect.
// Ports:
//   Clk, Reset                     clock, synchronous active-high reset
//   Stall, Flush                   hazard hold / squash of IF/ID
//   BranchTaken, BranchTarget      resolved taken branch and its target
//   Jump, JumpIndex                j/jal in ID and its instr[25:0]
//   JumpReg, JumpRegTarget         jr in ID and its rs value
//   Instruction                    combinational imem read data
//   PCAddress                      current PC to imem
//   IFID_Instruction/PCPlus4/Valid IF/ID pipeline register outputs
// Build option: define DELAY_SLOT_EN to keep the instruction fetched
// alongside a taken redirect as a valid branch delay slot.
module instruction_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h00000000,
    parameter logic [31:0] NOP_WORD = 32'h00000000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        Flush,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    input  logic        Jump,
    input  logic [25:0] JumpIndex,
    input  logic        JumpReg,
    input  logic [31:0] JumpRegTarget,
    input  logic [31:0] Instruction,
    output logic [31:0] PCAddress,
    output logic [31:0] IFID_Instruction,
    output logic [31:0] IFID_PCPlus4,
    output logic        IFID_Valid
);

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] target_raw;
    logic [31:0] target;
    logic        redirect;

    assign PCAddress = pc;
    assign pc_plus4  = pc + 32'd4;
    assign redirect  = JumpReg | Jump | BranchTaken;

    // jr outranks j, which outranks a taken branch
    always_comb begin
        target_raw = BranchTarget;
        if (JumpReg) begin
            target_raw = JumpRegTarget;
        end else if (Jump) begin
            target_raw = {IFID_PCPlus4[31:28], JumpIndex, 2'b00};
        end
    end

    // Every redirect target is word aligned
    assign target = {target_raw[31:2], 2'b00};

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc               <= RESET_PC;
            IFID_Instruction <= NOP_WORD;
            IFID_PCPlus4     <= 32'd0;
            IFID_Valid       <= 1'b0;
        end else begin
            // A redirect must win over a stall or the branch would be lost
            if (redirect) begin
                pc <= target;
            end else if (!Stall) begin
                pc <= pc_plus4;
            end

            if (Flush) begin
                IFID_Instruction <= NOP_WORD;
                IFID_PCPlus4     <= pc_plus4;
                IFID_Valid       <= 1'b0;
`ifdef DELAY_SLOT_EN
            end else if (redirect) begin
                // The word fetched with the redirect is the delay slot
                IFID_Instruction <= Instruction;
                IFID_PCPlus4     <= pc_plus4;
                IFID_Valid       <= 1'b1;
`else
            end else if (redirect) begin
                // Wrong-path fetch: squash it
                IFID_Instruction <= NOP_WORD;
                IFID_PCPlus4     <= pc_plus4;
                IFID_Valid       <= 1'b0;
`endif
            end else if (!Stall) begin
                IFID_Instruction <= Instruction;
                IFID_PCPlus4     <= pc_plus4;
                IFID_Valid       <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for instruction_fetch_stage with a combinational
// instruction memory where word i holds i*3.
module tb_instruction_fetch_stage;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Stall;
    logic        Flush;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic        Jump;
    logic [25:0] JumpIndex;
    logic        JumpReg;
    logic [31:0] JumpRegTarget;
    logic [31:0] Instruction;
    logic [31:0] PCAddress;
    logic [31:0] IFID_Instruction;
    logic [31:0] IFID_PCPlus4;
    logic        IFID_Valid;

    int errors = 0;
    int checks = 0;

    instruction_fetch_stage dut (
        .Clk(Clk),
        .Reset(Reset),
        .Stall(Stall),
        .Flush(Flush),
        .BranchTaken(BranchTaken),
        .BranchTarget(BranchTarget),
        .Jump(Jump),
        .JumpIndex(JumpIndex),
        .JumpReg(JumpReg),
        .JumpRegTarget(JumpRegTarget),
        .Instruction(Instruction),
        .PCAddress(PCAddress),
        .IFID_Instruction(IFID_Instruction),
        .IFID_PCPlus4(IFID_PCPlus4),
        .IFID_Valid(IFID_Valid)
    );

    always #5 Clk = ~Clk;

    assign Instruction = (PCAddress >> 2) * 32'd3;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [31:0] pc,
                           input logic [31:0] ins, input logic [31:0] p4,
                           input logic v);
        check({tag, ".pc"}, PCAddress, pc);
        check({tag, ".ins"}, IFID_Instruction, ins);
        check({tag, ".pc4"}, IFID_PCPlus4, p4);
        check({tag, ".valid"}, {31'd0, IFID_Valid}, {31'd0, v});
    endtask

    initial begin
        Reset = 1'b1;
        Stall = 1'b0;
        Flush = 1'b0;
        BranchTaken = 1'b0;
        BranchTarget = 32'd0;
        Jump = 1'b0;
        JumpIndex = 26'd0;
        JumpReg = 1'b0;
        JumpRegTarget = 32'd0;
        tick();
        tick();
        chk_all("reset", 32'h0, 32'h0, 32'h0, 1'b0);

        Reset = 1'b0;
        tick();
        chk_all("run1", 32'h4, 32'd0, 32'h4, 1'b1);
        tick();
        chk_all("run2", 32'h8, 32'd3, 32'h8, 1'b1);
        tick();
        chk_all("run3", 32'hC, 32'd6, 32'hC, 1'b1);
        tick();
        chk_all("run4", 32'h10, 32'd9, 32'h10, 1'b1);

        Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all("stall", 32'h10, 32'd9, 32'h10, 1'b1);
        end
        Stall = 1'b0;
        tick();
        chk_all("rel1", 32'h14, 32'd12, 32'h14, 1'b1);
        tick();
        chk_all("rel2", 32'h18, 32'd15, 32'h18, 1'b1);

        for (int k = 1; k <= 5; k++) begin
            tick();
            chk_all("walk", 32'h18 + 32'(4 * k), 32'(3 * (5 + k)),
                    32'h18 + 32'(4 * k), 1'b1);
        end

        Jump = 1'b1;
        JumpIndex = 26'd0;
        tick();
        Jump = 1'b0;
`ifdef DELAY_SLOT_EN
        chk_all("jump", 32'h0, 32'd33, 32'h30, 1'b1);
`else
        chk_all("jump", 32'h0, 32'd0, 32'h30, 1'b0);
`endif
        tick();
        chk_all("jump_next", 32'h4, 32'd0, 32'h4, 1'b1);

        BranchTaken = 1'b1;
        BranchTarget = 32'h47;
        Stall = 1'b1;
        tick();
        BranchTaken = 1'b0;
        Stall = 1'b0;
        check("br_stall.pc", PCAddress, 32'h44);
`ifdef DELAY_SLOT_EN
        check("br_stall.valid", {31'd0, IFID_Valid}, 32'd1);
`else
        check("br_stall.valid", {31'd0, IFID_Valid}, 32'd0);
        check("br_stall.pc4", IFID_PCPlus4, 32'h8);
`endif
        tick();
        chk_all("br_next", 32'h48, 32'd51, 32'h48, 1'b1);

        JumpReg = 1'b1;
        Jump = 1'b1;
        JumpRegTarget = 32'h100;
        JumpIndex = 26'h20;
        tick();
        Jump = 1'b0;
        check("jr_prio.pc", PCAddress, 32'h100);

        JumpRegTarget = 32'hFFFFFFFC;
        tick();
        JumpReg = 1'b0;
        check("jr_top.pc", PCAddress, 32'hFFFFFFFC);
        tick();
        chk_all("wrap", 32'h0, 32'hBFFFFFFD, 32'h0, 1'b1);

        Stall = 1'b1;
        Flush = 1'b1;
        tick();
        Flush = 1'b0;
        chk_all("flush_stall", 32'h0, 32'h0, 32'h4, 1'b0);

        BranchTaken = 1'b1;
        BranchTarget = 32'h200;
        Reset = 1'b1;
        tick();
        BranchTaken = 1'b0;
        Stall = 1'b0;
        Reset = 1'b0;
        chk_all("rst_mid", 32'h0, 32'h0, 32'h0, 1'b0);
        tick();
        chk_all("post_rst", 32'h4, 32'd0, 32'h4, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_stage.md
Name: instruction_fetch_stage

Overview:
- IF stage of the 5-stage MIPS pipeline.
- Owns the PC register and next-PC selection (PC+4, branch, j, jr).
- Drives the instruction memory word address and latches the returned instruction plus PC+4 into the IF/ID pipeline register.
- Honours stall from hazard detection and flush/redirect from ID/EX.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on Reset.
- NOP_WORD, 32'h00000000, instruction word inserted into IF/ID on flush/reset (sll $0,$0,0).

Ports:
- Clk  input  1  system clock, all state updates on rising edge
- Reset  input  1  synchronous, active-high reset
- Stall  input  1  hold PC and IF/ID (load-use hazard)
- Flush  input  1  squash IF/ID contents (exception/external squash)
- BranchTaken  input  1  branch resolved taken
- BranchTarget  input  32  branch target address
- Jump  input  1  j/jal in ID
- JumpIndex  input  26  instr[25:0] of the jump
- JumpReg  input  1  jr in ID
- JumpRegTarget  input  32  rs value for jr
- Instruction  input  32  combinational read data from instruction memory
- PCAddress  output  32  current PC, drives instruction memory Address
- IFID_Instruction  output  32  latched instruction
- IFID_PCPlus4  output  32  latched PC+4 of that instruction
- IFID_Valid  output  1  1 = IF/ID holds a real fetched instruction

Behaviour:
- Reset, checked on rising edge only:
  - PC <= RESET_PC.
  - IFID_Instruction <= NOP_WORD, IFID_PCPlus4 <= 0, IFID_Valid <= 0.
  - Reset overrides every other input.
- PCAddress = PC register, combinational output; no extra latency to memory.
- PCPlus4 = PC + 4, 32-bit modulo arithmetic: 0xFFFFFFFC wraps to 0x00000000.
- Redirect selection, priority high→low:
  - JumpReg: JumpRegTarget.
  - Jump: {IFID_PCPlus4[31:28], JumpIndex, 2'b00}.
  - BranchTaken: BranchTarget.
  - Redirect = any of the three asserted.
  - Bits [1:0] of every redirect target are forced to 00.
- PC update each cycle, priority:
  1. Reset.
  2. Redirect: PC <= target. Redirect wins over Stall.
  3. Stall: PC holds.
  4. Otherwise PC <= PCPlus4.
- IF/ID update each cycle, priority:
  1. Reset.
  2. Flush: load NOP_WORD, PCPlus4 of current PC, Valid=0. Flush beats Stall.
  3. Redirect with DELAY_SLOT_EN undefined: squash the same way as Flush.
  4. Stall: hold all IF/ID outputs.
  5. Otherwise: IFID_Instruction <= Instruction, IFID_PCPlus4 <= PCPlus4, IFID_Valid <= 1.
- Latency: instruction at address p appears on IFID_* one rising edge after PCAddress == p.
- Stall and Flush together: PC holds (absent redirect), IF/ID squashed.
- Stall held N cycles: PCAddress and IFID_* stay constant for N cycles. On release, fetch resumes at the held PC with no skipped or duplicated instruction.
- Reset asserted mid-redirect or mid-stall: the next cycle is identical to post-reset state; pending redirect is lost.
- First instruction after Reset is latched into IF/ID on the first edge with Reset low.

Optional Feature:
- Macro: DELAY_SLOT_EN.
- Defined: MIPS branch delay slot.
  - On redirect (no Flush), IF/ID captures the instruction currently being fetched with Valid=1.
  - PC still loads the target.
- Undefined: redirect squashes IF/ID to NOP_WORD/Valid=0, losing one cycle per taken branch or jump.
- Flush and Stall semantics are identical in both builds.

Test Plan:
- Reset 2 cycles, then free-run with memory[i] = i*3 → PCAddress 0,4,8,…; IFID_Instruction 0,3,6 on successive edges; IFID_PCPlus4 = 4,8,12; Valid=1 from first post-reset edge.
- At PC=0x10 assert Stall 3 cycles → PCAddress stays 0x10 and IF/ID holds word 9 (from 0x0C) for 3 cycles; after release IF/ID gets 12, then 15.
- Jump with IFID_PCPlus4=0x0000002C, JumpIndex=0 (j loop) → next PCAddress=0x00000000.
  - Without DELAY_SLOT_EN: IFID_Valid=0 and IFID_Instruction=0 for one cycle.
  - With DELAY_SLOT_EN: IF/ID holds the fetched slot word, Valid=1.
- BranchTaken with BranchTarget=0x00000047 plus Stall in the same cycle → PCAddress=0x00000044 next cycle (redirect beats stall, low bits cleared).
- JumpReg=1 and Jump=1 together, JumpRegTarget=0x100, JumpIndex=0x20 → PCAddress=0x100.
- Load PC=0xFFFFFFFC via JumpReg, run one cycle → PCAddress=0x00000000. Assert Reset during a Stall → PC=RESET_PC, IFID_Valid=0 next cycle.
